// File: rtl/irq_event_capture.sv
// -----------------------------------------------------------------------------
// irq_event_capture
//   Conditions NUM_SRC raw asynchronous interrupt sources for the AXI-Lite
//   interrupt controller. Each source is synchronized, edge- or level-detected
//   and captured into a sticky pending bit with an overflow flag. A shared
//   coalescing FSM holds intr_out low until enough events (or a timeout) have
//   accumulated, then presents the pending vector until all sources are acked.
//
// Ports
//   ACLK              in   1        system clock, rising edge
//   ARESETN           in   1        synchronous active-low reset
//   src_in            in   NUM_SRC  raw asynchronous interrupt sources
//   cfg_edge          in   NUM_SRC  1 = rising-edge mode, 0 = level-high mode
//   cfg_coal_thresh   in   CNT_W    events needed to fire (0/1 = first event)
//   cfg_coal_timeout  in   TMO_W    GATHER cycles before forced fire, 0 = off
//   intr_ack          in   NUM_SRC  per-source clear pulse
//   intr_out          out  NUM_SRC  pending vector towards the controller
//   overflow          out  NUM_SRC  edge event while already pending (sticky)
//   busy              out  1        coalescing FSM not idle
// -----------------------------------------------------------------------------
module irq_event_capture #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TMO_W       = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] cfg_edge,
  input  logic [CNT_W-1:0]   cfg_coal_thresh,
  input  logic [TMO_W-1:0]   cfg_coal_timeout,
  input  logic [NUM_SRC-1:0] intr_ack,
  output logic [NUM_SRC-1:0] intr_out,
  output logic [NUM_SRC-1:0] overflow,
  output logic               busy
);

  localparam int EVN_W = $clog2(NUM_SRC + 1);
  localparam int SUM_W = ((CNT_W > EVN_W) ? CNT_W : EVN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    FIRE   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Per-source capture path
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_last;
  logic [NUM_SRC-1:0] prev_reg;
  logic [NUM_SRC-1:0] ev_next;
  logic [NUM_SRC-1:0] ev_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] overflow_reg;
  logic [NUM_SRC-1:0] overflow_next;

  assign sync_last = sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // prev_reg resets to 0, so a source already high at reset release
      // produces exactly one edge event.
      assign ev_next[gi] = cfg_edge[gi] ? (sync_last[gi] & ~prev_reg[gi])
                                        : sync_last[gi];
      // An event wins over a coincident ack, keeping the source pending.
      assign pending_next[gi] = ev_reg[gi] | (pending_reg[gi] & ~intr_ack[gi]);
      // Any ack clears overflow, including one coincident with a new event.
      assign overflow_next[gi] = ~intr_ack[gi] &
                                 (overflow_reg[gi] |
                                  (ev_reg[gi] & pending_reg[gi] & cfg_edge[gi]));
    end
  endgenerate

  // The event is registered once more after detection so that pending rises
  // SYNC_STAGES+2 edges after the source becomes stable.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
      prev_reg     <= '0;
      ev_reg       <= '0;
      pending_reg  <= '0;
      overflow_reg <= '0;
    end else begin
      sync_reg[0] <= src_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg     <= sync_last;
      ev_reg       <= ev_next;
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Event counting helpers for the coalescing FSM
  // ---------------------------------------------------------------------------
  logic [EVN_W-1:0] evn;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] evn_sat;
  logic [TMO_W-1:0] tmr_inc;
  logic             evn_ge_thresh;
  logic             gather_fire;

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [TMO_W-1:0]   tmr_reg;
  logic [NUM_SRC-1:0] intr_out_reg;
  logic               busy_reg;

  always_comb begin
    evn = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      evn = evn + EVN_W'(ev_reg[i]);
    end
  end

  assign cnt_sum = SUM_W'(cnt_reg) + SUM_W'(evn);
  assign cnt_sat = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  assign evn_sat = (SUM_W'(evn) > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(evn);
  assign tmr_inc = (tmr_reg == TMO_MAX) ? TMO_MAX : tmr_reg + TMO_W'(1);

  // The IDLE decision uses the raw event count, before any saturation.
  assign evn_ge_thresh = SUM_W'(evn) >= SUM_W'(cfg_coal_thresh);
  assign gather_fire   = (cnt_sat >= cfg_coal_thresh) ||
                         ((cfg_coal_timeout != '0) && (tmr_inc >= cfg_coal_timeout));

  // ---------------------------------------------------------------------------
  // Coalescing FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      tmr_reg      <= '0;
      intr_out_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      // intr_out follows pending one cycle late, only while firing.
      intr_out_reg <= (state_reg == FIRE) ? pending_reg : '0;

      case (state_reg)
        IDLE: begin
          if (|ev_reg) begin
            cnt_reg  <= evn_sat;
            tmr_reg  <= '0;
            busy_reg <= 1'b1;
            if ((cfg_coal_thresh <= CNT_W'(1)) || evn_ge_thresh) begin
              state_reg <= FIRE;
            end else begin
              state_reg <= GATHER;
            end
          end
        end

        GATHER: begin
          cnt_reg <= cnt_sat;
          tmr_reg <= tmr_inc;
          if (gather_fire) begin
            state_reg <= FIRE;
          end else if (pending_next == '0) begin
            // Everything was acked before the threshold was reached.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tmr_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end

        FIRE: begin
          // Looking at pending_next means an event landing in the same cycle
          // as the final ack keeps the FSM firing instead of being stranded.
          if (pending_next == '0) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tmr_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          tmr_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign intr_out = intr_out_reg;
  assign overflow = overflow_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_irq_event_capture.sv
// -----------------------------------------------------------------------------
// tb_irq_event_capture
//   Randomized bench for irq_event_capture. A behavioural model (sample
//   history, event pipeline, pending set/clear rules, integer coalescing
//   counters) predicts intr_out/overflow/busy every cycle; a few directed
//   scenarios pin the model with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_irq_event_capture;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int TW   = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [N-1:0]  src_in = '0;
  logic [N-1:0]  cfg_edge = '1;
  logic [CW-1:0] cfg_coal_thresh = 8'd1;
  logic [TW-1:0] cfg_coal_timeout = '0;
  logic [N-1:0]  intr_ack = '0;
  logic [N-1:0]  intr_out;
  logic [N-1:0]  overflow;
  logic          busy;

  irq_event_capture #(
    .NUM_SRC(N), .SYNC_STAGES(S), .CNT_W(CW), .TMO_W(TW)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .src_in(src_in),
    .cfg_edge(cfg_edge),
    .cfg_coal_thresh(cfg_coal_thresh),
    .cfg_coal_timeout(cfg_coal_timeout),
    .intr_ack(intr_ack),
    .intr_out(intr_out),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   m_hist[j] : src_in sampled j+1 edges ago (zero after reset)
  //   m_evq     : event detected this edge, applied to pending next edge
  //   m_mode    : 0 idle, 1 gathering, 2 firing
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_hist [0:S];
  logic [N-1:0] m_evq;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ovf;
  int           m_mode;
  int           m_cnt;
  int           m_tmr;
  logic [N-1:0] exp_intr = '0;
  logic         exp_busy = 1'b0;

  task automatic model_step();
    logic [N-1:0] ev_use;
    int evn, thr, tmo;
    if (!ARESETN) begin
      for (int j = 0; j <= S; j++) m_hist[j] = '0;
      m_evq = '0; m_pend = '0; m_ovf = '0;
      m_mode = 0; m_cnt = 0; m_tmr = 0;
      exp_intr = '0; exp_busy = 1'b0;
      return;
    end
    exp_intr = (m_mode == 2) ? m_pend : '0;
    ev_use = m_evq;
    // s = source sampled S edges ago, p = one edge older still
    m_evq = (m_hist[S-1] & ~m_hist[S] & cfg_edge) | (m_hist[S-1] & ~cfg_edge);
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = src_in;

    for (int i = 0; i < N; i++) begin
      if (ev_use[i]) begin
        if (m_pend[i] && !intr_ack[i] && cfg_edge[i]) m_ovf[i] = 1'b1;
        if (intr_ack[i]) m_ovf[i] = 1'b0;
        m_pend[i] = 1'b1;
      end else if (intr_ack[i]) begin
        m_pend[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end
    end

    evn = $countones(ev_use);
    thr = int'(cfg_coal_thresh);
    tmo = int'(cfg_coal_timeout);
    case (m_mode)
      0: if (evn > 0) begin
        m_cnt  = (evn > CMAX) ? CMAX : evn;
        m_tmr  = 0;
        m_mode = (thr <= 1 || evn >= thr) ? 2 : 1;
      end
      1: begin
        m_cnt = (m_cnt + evn > CMAX) ? CMAX : m_cnt + evn;
        m_tmr = (m_tmr + 1 > TMAX) ? TMAX : m_tmr + 1;
        if (m_cnt >= thr || (tmo != 0 && m_tmr >= tmo)) m_mode = 2;
        else if (m_pend == '0) begin m_mode = 0; m_cnt = 0; m_tmr = 0; end
      end
      default: if (m_pend == '0) begin m_mode = 0; m_cnt = 0; m_tmr = 0; end
    endcase
    exp_busy = (m_mode != 0);
  endtask

  initial forever begin
    @(posedge ACLK);
    model_step();
  end

  // Compare process: outputs sampled on the falling edge every cycle.
  initial forever begin
    @(negedge ACLK);
    if (chk_en) begin
      check("intr_out", 32'(intr_out), 32'(exp_intr));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("busy",     32'(busy),     32'(exp_busy));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0; src_in = '0; intr_ack = '0;
    cycles(1);
    ARESETN = 1'b1;
  endtask

  initial begin
    cycles(3);
    chk_en = 1'b1;
    ARESETN = 1'b1;

    // T1: edge mode, thresh 1, single rise on src 0
    cfg_edge = '1; cfg_coal_thresh = 8'd1; cfg_coal_timeout = '0;
    src_in = 4'b0001;
    cycles(4);
    check("t1_intr_before_fire", 32'(intr_out), 32'h0);
    cycles(1);
    check("t1_intr_fire", 32'(intr_out), 32'h1);
    check("t1_busy_fire", 32'(busy), 32'h1);
    intr_ack = 4'b0001; cycles(1); intr_ack = '0;
    cycles(1);
    check("t1_intr_after_ack", 32'(intr_out), 32'h0);
    check("t1_busy_after_ack", 32'(busy), 32'h0);
    src_in = '0; cycles(4);

    // T3: thresh 5, timeout 20, one pulse on src 2
    do_reset();
    cfg_coal_thresh = 8'd5; cfg_coal_timeout = 16'd20;
    src_in = 4'b0100; cycles(2); src_in = '0;
    cycles(2);
    check("t3_busy_gather", 32'(busy), 32'h1);
    cycles(20);
    check("t3_intr_hold", 32'(intr_out), 32'h0);
    cycles(1);
    check("t3_intr_timeout", 32'(intr_out), 32'h4);
    intr_ack = '1; cycles(1); intr_ack = '0; cycles(3);

    // T4: overflow on src 3, then ack coincident with a third edge
    do_reset();
    cfg_coal_thresh = 8'd1; cfg_coal_timeout = '0;
    src_in = 4'b1000; cycles(2); src_in = '0; cycles(2);
    src_in = 4'b1000; cycles(2); src_in = '0; cycles(6);
    check("t4_overflow_set", 32'(overflow), 32'h8);
    check("t4_intr", 32'(intr_out), 32'h8);
    src_in = 4'b1000; cycles(3);
    intr_ack = 4'b1000; cycles(1); intr_ack = '0;
    check("t4_overflow_clr", 32'(overflow), 32'h0);
    cycles(1);
    check("t4_pending_kept", 32'(intr_out), 32'h8);
    src_in = '0; intr_ack = '1; cycles(1); intr_ack = '0; cycles(3);

    // T6: reset while firing with pending 1011, sources held high
    do_reset();
    src_in = 4'b1011; cycles(8);
    check("t6_intr_fire", 32'(intr_out), 32'hB);
    ARESETN = 1'b0; cycles(1);
    check("t6_intr_rst", 32'(intr_out), 32'h0);
    check("t6_busy_rst", 32'(busy), 32'h0);
    ARESETN = 1'b1;
    cycles(S + 3);
    check("t6_refire", 32'(intr_out), 32'hB);
    src_in = '0; intr_ack = '1; cycles(1); intr_ack = '0; cycles(3);

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        cfg_edge         = N'($urandom);
        cfg_coal_thresh  = CW'($urandom_range(0, 6));
        cfg_coal_timeout = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 30));
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) src_in[i] = ~src_in[i];
        intr_ack[i] = ($urandom_range(0, 9) == 0);
      end
      ARESETN = ($urandom_range(0, 599) != 0);
      cycles(1);
    end
    ARESETN = 1'b1;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
